imem_arb: RTL
=============

# imem_arb

Arbiter and sequencer for the single-port instruction memory of the MIPS core. It owns every access to the memory and shares the single port between two requesters: the IF-stage fetch port (read) and the program loader port (write). After reset it stays in a boot phase that gives the loader exclusive access. Once the loader signals completion, it enters a run phase where loader writes take priority under a starvation bound. The memory behind it has a 1-cycle synchronous read.

## Interface

Parameters:
- DEPTH, 1024: memory depth in 32-bit words; power of two.
- BASE, 32'h0000_3000: byte address of word 0.
- STARVE_MAX, 4: maximum consecutive loader grants while a fetch is waiting.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request.
- f_pc  in  32  fetch byte address.
- f_gnt  out  1  fetch accepted this cycle (combinational).
- f_valid  out  1  fetch result valid; one cycle after f_gnt.
- f_instr  out  32  fetched word.
- f_err  out  1  address error; qualified by f_valid.
- ld_req  in  1  loader write request.
- ld_addr  in  32  loader byte address.
- ld_wdata  in  32  loader write data.
- ld_done  in  1  single-cycle pulse: program image complete.
- ld_gnt  out  1  write accepted this cycle (combinational).
- ld_err  out  1  accepted write was dropped because of an address error (combinational, with ld_gnt).
- running  out  1  0 in BOOT, 1 in RUN.
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  $clog2(DEPTH)  memory word index.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid the cycle after a read with mem_en=1, mem_we=0.

## Operation

- **Address check.** Applied identically to f_pc and ld_addr.
  - The address is legal iff addr[1:0]==0 and BASE <= addr < BASE+4*DEPTH.
  - Word index = (addr-BASE)[$clog2(DEPTH)+1:2].
  - Subtraction is 32-bit unsigned; there is no wrap-around.
- **States.** Two states: BOOT (the reset state) and RUN.
- **BOOT behaviour.**
  - f_gnt=0 always.
  - ld_gnt=ld_req.
- **BOOT to RUN.**
  - ld_done=1 moves the block to RUN at the next edge.
  - If ld_req and ld_done are both high in the same cycle, that write is still performed.
  - ld_done is ignored in RUN.
  - There is no return to BOOT except through reset.
- **RUN arbitration.**
  - Loader has priority.
  - A fetch wins instead when f_req=1 and starve_cnt==STARVE_MAX.
- **starve_cnt.**
  - Increments on each loader grant made while f_req=1.
  - Clears on any fetch grant, or when f_req=0.
  - Saturates at STARVE_MAX.
- **Granted fetch, legal address:** mem_en=1, mem_we=0, mem_addr=index.
- **Granted fetch, illegal address:**
  - No memory access (mem_en=0).
  - Next cycle: f_valid=1, f_err=1, f_instr=0.
- **Granted write, legal address:** mem_en=1, mem_we=1, mem_wdata=ld_wdata.
- **Granted write, illegal address:** ld_err=1 and the write is dropped (mem_en=0).
- **Fetch result.**
  - f_instr=mem_rdata when f_valid=1 and f_err=0.
  - f_instr=0 whenever f_valid=0.
- **Idle memory port.** mem_en=0, mem_we=0, and mem_addr/mem_wdata are driven 0.

## Timing

- **Reset values:**
  - State=BOOT, running=0, starve_cnt=0.
  - f_valid=0, f_err=0, f_instr=0.
  - All mem_* outputs = 0; f_gnt=0, ld_gnt=0.
- **Handshakes.**
  - A requester holds its request and its address/data stable until the matching gnt.
  - The transfer occurs in the cycle where req and gnt are both 1.
  - Requesters advance on gnt; there is no backpressure on f_valid.
- **Fetch latency and throughput.**
  - Latency is exactly 1 cycle from f_gnt to f_valid.
  - Back-to-back fetch grants are allowed: 1 fetch per cycle.
- **Write completion.** A write completes at the edge closing its ld_gnt cycle. A fetch granted in the following cycle to the same word returns the new data.
- **Reset mid-operation.**
  - An outstanding read is discarded; f_valid stays 0.
  - A write that is mid-cycle when reset asserts has undefined effect on memory.
- **Simultaneous requests.**
  - In BOOT, f_req is ignored.
  - In RUN, at most one of f_gnt and ld_gnt is 1 in any cycle.

## Structure

- **Package imem_pkg** holds:
  - the state enum {BOOT, RUN};
  - the default BASE constant;
  - the STARVE_MAX default;
  - the function that computes the word-index width.
- **Sub-module imem_addr_chk.** Combinational; inputs addr, BASE, DEPTH; outputs legal and index. Instantiated twice, once for fetch and once for loader.
- **Top level** holds the FSM, the starvation counter and the f_valid/f_err registers.

## Test plan

- **Boot load.** Write 0x3C01_1234 to 0x3000 and 0x3402_0001 to 0x3004, pulse ld_done, then fetch 0x3000 and 0x3004 back-to-back.
  - Expect f_gnt on 2 consecutive cycles.
  - Expect f_valid on the next 2 cycles with those words; running=1 after the pulse.
- **Fetch blocked in BOOT.** Hold f_req=1 for 5 cycles before ld_done.
  - Expect f_gnt=0 throughout.
  - Expect the first f_gnt the cycle after running rises.
- **Starvation bound in RUN.** Hold ld_req=1 and f_req=1 continuously.
  - Expect grant pattern: 4 ld_gnt, 1 f_gnt, repeating.
  - Expect never both grants in the same cycle.
- **Address errors.**
  - Fetch 0x3002 → f_valid=1, f_err=1, f_instr=0, mem_en=0.
  - Fetch 0x4000 (DEPTH=1024) → f_err=1.
  - Loader write to 0x2FFC → ld_gnt=1, ld_err=1, mem_en=0.
- **Write-then-read.** In RUN, write 0xDEAD_BEEF to 0x3010, then fetch 0x3010 the next cycle → f_instr=0xDEAD_BEEF.
- **Reset mid-fetch.** Assert rst_n=0 in the cycle after f_gnt.
  - Expect f_valid=0 and running=0 immediately.
  - Expect all mem_* outputs = 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Imported by the arbiter top and its address checker.
package imem_pkg;

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [31:0] BASE_DEF   = 32'h0000_3000;
   localparam int          STARVE_DEF = 4;

   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/imem_addr_chk.sv
// Byte-address legality check and word-index extraction.
// Purely combinational; one instance per requester.
module imem_addr_chk
   import imem_pkg::*;
#(
   parameter int          DEPTH = 1024,
   parameter logic [31:0] BASE  = BASE_DEF,
   localparam int         AW    = idx_w(DEPTH)
) (
   input  logic [31:0]   addr,
   output logic          legal,
   output logic [AW-1:0] index
);

   // window size kept at 33 bits so BASE near the top of memory cannot wrap
   localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

   logic [31:0] w_off;
   logic        w_align;
   logic        w_above;
   logic        w_below;

   assign w_off   = addr - BASE;
   assign w_align = (addr[1:0] == 2'b00);
   assign w_above = (addr >= BASE);
   assign w_below = ({1'b0, w_off} < SPAN);
   assign legal   = w_align && w_above && w_below;
   assign index   = w_off[AW+1:2];

endmodule

// File: rtl/imem_arb.sv
// Single-port instruction memory arbiter: loader-only BOOT phase,
// then loader-priority RUN phase with a fetch starvation bound.
module imem_arb
   import imem_pkg::*;
#(
   parameter int          DEPTH      = 1024,
   parameter logic [31:0] BASE       = BASE_DEF,
   parameter int          STARVE_MAX = STARVE_DEF,
   localparam int         AW         = idx_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          f_req,
   input  logic [31:0]   f_pc,
   output logic          f_gnt,
   output logic          f_valid,
   output logic [31:0]   f_instr,
   output logic          f_err,
   input  logic          ld_req,
   input  logic [31:0]   ld_addr,
   input  logic [31:0]   ld_wdata,
   input  logic          ld_done,
   output logic          ld_gnt,
   output logic          ld_err,
   output logic          running,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

   state_e        r_state;
   logic [CW-1:0] r_starve;
   logic          r_fv;
   logic          r_ferr;

   logic          w_run;
   logic          w_f_win;
   logic          w_f_gnt;
   logic          w_ld_gnt;
   logic          w_f_legal;
   logic          w_ld_legal;
   logic [AW-1:0] w_f_idx;
   logic [AW-1:0] w_ld_idx;

   imem_addr_chk #(
      .DEPTH (DEPTH),
      .BASE  (BASE)
   ) u_f_chk (
      .addr  (f_pc),
      .legal (w_f_legal),
      .index (w_f_idx)
   );

   imem_addr_chk #(
      .DEPTH (DEPTH),
      .BASE  (BASE)
   ) u_ld_chk (
      .addr  (ld_addr),
      .legal (w_ld_legal),
      .index (w_ld_idx)
   );

   assign w_run   = (r_state == RUN);
   assign w_f_win = w_run && f_req && (r_starve == SMAX);

   // no grants at all while reset is held
   always_comb begin
      w_f_gnt  = 1'b0;
      w_ld_gnt = 1'b0;
      if (rst_n) begin
         if (!w_run) begin
            w_ld_gnt = ld_req;
         end else if (w_f_win) begin
            w_f_gnt = 1'b1;
         end else if (ld_req) begin
            w_ld_gnt = 1'b1;
         end else begin
            w_f_gnt = f_req;
         end
      end
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_f_gnt && w_f_legal) begin
         mem_en   = 1'b1;
         mem_addr = w_f_idx;
      end else if (w_ld_gnt && w_ld_legal) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = w_ld_idx;
         mem_wdata = ld_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= BOOT;
      end else if (!w_run && ld_done) begin
         r_state <= RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve <= '0;
      end else if (!w_run || !f_req || w_f_gnt) begin
         r_starve <= '0;
      end else if (w_ld_gnt && (r_starve != SMAX)) begin
         r_starve <= r_starve + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fv   <= 1'b0;
         r_ferr <= 1'b0;
      end else begin
         r_fv   <= w_f_gnt;
         r_ferr <= w_f_gnt && !w_f_legal;
      end
   end

   assign f_gnt   = w_f_gnt;
   assign ld_gnt  = w_ld_gnt;
   assign ld_err  = w_ld_gnt && !w_ld_legal;
   assign running = w_run;
   assign f_valid = r_fv;
   assign f_err   = r_ferr;
   assign f_instr = (r_fv && !r_ferr) ? mem_rdata : 32'h0;

endmodule
